axi_read_burst_splitter: RTL and testbench

AXI_READ_BURST_SPLITTER -- requirements
Module: axi_read_burst_splitter

---
 rtl/axi_split_pkg.sv | 22 ++
 rtl/axi_read_burst_splitter_if.sv | 44 ++++
 rtl/axi_beat_addr_calc.sv | 47 ++++
 rtl/axi_read_burst_splitter.sv | 147 ++++++++++++++
 tb/tb_axi_read_burst_splitter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_split_pkg.sv
// Shared definitions for the AXI read burst splitter.
// Holds the AXI burst encodings, the splitter state enum, and a helper that
// says whether a burst length is legal for a WRAP burst.
package axi_split_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // AXI allows WRAP bursts of 2, 4, 8 or 16 beats only.
  function automatic logic is_wrap_len(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_read_burst_splitter_if.sv
// AXI read channel bundle (AR + R) used on both sides of the splitter.
// Modports:
//   master - drives AR payload/valid and r_ready; receives ar_ready and R.
//   slave  - receives AR payload/valid and r_ready; drives ar_ready and R.
interface axi_read_burst_splitter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
) ();

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic [2:0]            ar_prot;
  logic [USER_WIDTH-1:0] ar_user;

  logic                  r_valid;
  logic                  r_ready;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;

  modport master (
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user,
    output r_ready
  );

  modport slave (
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user,
    input  r_ready
  );

endinterface

// File: rtl/axi_beat_addr_calc.sv
// Combinational address generator for one beat of an AXI burst.
// Ports:
//   addr      - start address of the burst
//   len/size  - AXI burst length (beats-1) and log2 bytes per beat
//   burst     - burst type; WRAP with an illegal length behaves as INCR
//   beat      - beat index (0..len)
//   beat_addr - address of that beat
module axi_beat_addr_calc
  import axi_split_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  burst_e                burst,
  input  logic [7:0]            beat,
  output logic [ADDR_WIDTH-1:0] beat_addr
);

  logic [ADDR_WIDTH-1:0] size_mask;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_addr;

  assign size_mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
  assign aligned   = addr & ~size_mask;
  assign step      = ADDR_WIDTH'(beat) << size;
  // Wrap window is (len+1) beats of 2^size bytes, always a power of two.
  assign wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);

  // The first INCR beat keeps the caller's (possibly unaligned) address.
  assign incr_addr = (beat == 8'd0) ? addr : aligned + step;
  assign wrap_addr = (addr & ~wrap_mask) | ((aligned + step) & wrap_mask);

  always_comb begin
    beat_addr = incr_addr;
    if (burst == BURST_FIXED) begin
      beat_addr = addr;
    end else if ((burst == BURST_WRAP) && is_wrap_len(len)) begin
      beat_addr = wrap_addr;
    end
  end

endmodule

// File: rtl/axi_read_burst_splitter.sv
// Splits one upstream AXI read burst into single-beat downstream reads.
// One upstream burst is in flight at a time; up to MAX_OUT (1..16) downstream
// single-beat ARs may be outstanding. R beats pass through combinationally and
// s_r_last is regenerated from the beat count (downstream r_last is ignored).
// Ports:
//   clk_i  - clock, all state on the rising edge
//   rst_i  - synchronous active-high reset; abandons any burst in progress
//   s_axi  - upstream side (accepts bursts, returns R beats)
//   m_axi  - downstream side (issues len=0 INCR reads, accepts R beats)
module axi_read_burst_splitter
  import axi_split_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  parameter int MAX_OUT    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  axi_read_burst_splitter_if.slave    s_axi,
  axi_read_burst_splitter_if.master   m_axi
);

  state_e                state_reg, state_next;
  logic [8:0]            issue_cnt_reg, rcv_cnt_reg;
  logic [8:0]            outstanding;

  logic [ID_WIDTH-1:0]   id_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]            len_reg;
  logic [2:0]            size_reg;
  burst_e                burst_reg;
  logic [2:0]            prot_reg;
  logic [USER_WIDTH-1:0] user_reg;

  logic                  s_ar_ready, m_ar_valid, m_r_ready, s_r_valid;
  logic                  ar_accept, m_ar_fire, s_r_fire;
  logic                  can_issue, r_last;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_WIDTH-1:0] r_data;

  assign outstanding = issue_cnt_reg - rcv_cnt_reg;
  assign can_issue   = (issue_cnt_reg <= {1'b0, len_reg}) && (outstanding < 9'(MAX_OUT));
  assign r_last      = (rcv_cnt_reg == {1'b0, len_reg});

  assign ar_accept = s_axi.ar_valid && s_ar_ready;
  assign m_ar_fire = m_ar_valid && m_axi.ar_ready;
  assign s_r_fire  = s_r_valid && s_axi.r_ready;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (ar_accept) state_next = ST_BUSY;
      ST_BUSY: if (s_r_fire && r_last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs; all held low while reset is asserted.
  always_comb begin
    s_ar_ready = 1'b0;
    m_ar_valid = 1'b0;
    m_r_ready  = 1'b0;
    s_r_valid  = 1'b0;
    if (!rst_i) begin
      case (state_reg)
        ST_IDLE: s_ar_ready = 1'b1;
        ST_BUSY: begin
          m_ar_valid = can_issue;
          m_r_ready  = s_axi.r_ready;
          s_r_valid  = m_axi.r_valid;
        end
        default: ;
      endcase
    end
  end

  // Beat counters; simultaneous issue and return leave outstanding unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_cnt_reg <= '0;
      rcv_cnt_reg   <= '0;
    end else if (ar_accept) begin
      issue_cnt_reg <= '0;
      rcv_cnt_reg   <= '0;
    end else begin
      if (m_ar_fire) issue_cnt_reg <= issue_cnt_reg + 9'd1;
      if (s_r_fire)  rcv_cnt_reg   <= rcv_cnt_reg + 9'd1;
    end
  end

  // Captured burst payload; only meaningful while BUSY.
  always_ff @(posedge clk_i) begin
    if (ar_accept) begin
      id_reg    <= s_axi.ar_id;
      addr_reg  <= s_axi.ar_addr;
      len_reg   <= s_axi.ar_len;
      size_reg  <= s_axi.ar_size;
      burst_reg <= burst_e'(s_axi.ar_burst);
      prot_reg  <= s_axi.ar_prot;
      user_reg  <= s_axi.ar_user;
    end
  end

  axi_beat_addr_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_calc (
    .addr      (addr_reg),
    .len       (len_reg),
    .size      (size_reg),
    .burst     (burst_reg),
    .beat      (issue_cnt_reg[7:0]),
    .beat_addr (beat_addr)
  );

  assign s_axi.ar_ready = s_ar_ready;

  assign m_axi.ar_valid = m_ar_valid;
  assign m_axi.ar_id    = id_reg;
  assign m_axi.ar_addr  = beat_addr;
  assign m_axi.ar_len   = 8'd0;
  assign m_axi.ar_size  = size_reg;
  assign m_axi.ar_burst = BURST_INCR;
  assign m_axi.ar_prot  = prot_reg;
  assign m_axi.ar_user  = user_reg;
  assign m_axi.r_ready  = m_r_ready;

  assign r_data         = m_axi.r_data;
  assign s_axi.r_valid  = s_r_valid;
  assign s_axi.r_id     = m_axi.r_id;
  assign s_axi.r_data   = r_data;
  assign s_axi.r_resp   = m_axi.r_resp;
  assign s_axi.r_last   = r_last;
  assign s_axi.r_user   = m_axi.r_user;

endmodule

// File: tb/tb_axi_read_burst_splitter.sv
// Directed bench for axi_read_burst_splitter: drives upstream bursts, plays a
// downstream single-beat responder, and compares addresses, R beats and
// handshake behaviour against hand-computed tables.
`timescale 1ns/1ps
module tb_axi_read_burst_splitter;
  import axi_split_pkg::*;

  localparam int AW = 64, DW = 64, IW = 4, UW = 1, MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_read_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) s_if ();
  axi_read_burst_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) m_if ();

  axi_read_burst_splitter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .MAX_OUT(MO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .s_axi (s_if),
    .m_axi (m_if)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_addr [0:15];
  int r_delay, stall_start, stall_len, abort_at;
  bit err_mode;
  int issued, rcv, max_seen, issued_pre;
  logic [63:0] q_addr[$];
  logic [3:0]  q_id[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    r_delay = 0; stall_start = 1000; stall_len = 0; abort_at = -1; err_mode = 0;
  endtask

  function automatic logic [1:0] resp_for(input int k);
    if (err_mode && k == 1) return 2'b10;
    if (err_mode && k == 2) return 2'b11;
    return 2'b00;
  endfunction

  task automatic start_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    s_if.ar_valid = 1'b1; s_if.ar_id = id; s_if.ar_addr = addr; s_if.ar_len = len;
    s_if.ar_size = size; s_if.ar_burst = burst; s_if.ar_prot = 3'b010; s_if.ar_user = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #4;
      if (s_if.ar_ready === 1'b1) ok = 1;
      step();
    end
    s_if.ar_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL ar_accept: s_ar_ready got 0 for 20 cycles, need 1");
    end
  endtask

  task automatic run_burst(input logic [3:0] t_id, input logic [63:0] t_addr, input logic [7:0] t_len,
                           input logic [2:0] t_size, input logic [1:0] t_burst);
    bit done = 0;
    logic [63:0] exp_data;
    logic exp_last;
    issued = 0; rcv = 0; max_seen = 0; issued_pre = -1;
    q_addr.delete(); q_id.delete();
    start_ar(t_id, t_addr, t_len, t_size, t_burst);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      m_if.ar_ready = 1'b1;
      s_if.r_ready  = !(cyc >= stall_start && cyc < stall_start + stall_len);
      m_if.r_valid  = (cyc >= r_delay) && (q_addr.size() > 0);
      if (q_addr.size() > 0) begin
        m_if.r_id   = q_id[0];
        m_if.r_data = {24'hD00D00, 8'(rcv), q_addr[0][31:0]};
        m_if.r_resp = resp_for(rcv);
        m_if.r_user = 1'(rcv);
        m_if.r_last = 1'b1;
      end
      #4;
      if (!s_if.r_ready) begin
        vectors++;
        if (m_if.r_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_m_r_ready: cyc %0d got %b need 0", cyc, m_if.r_ready);
        end
      end
      if (issued - rcv >= MO) begin
        vectors++;
        if (m_if.ar_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL max_out_gate: cyc %0d outstanding %0d m_ar_valid got %b need 0", cyc, issued - rcv, m_if.ar_valid);
        end
      end
      if (m_if.ar_valid === 1'b1) begin
        vectors++;
        if (issued > int'(t_len)) begin
          miscompares++;
          $display("FAIL extra_ar: beat %0d addr got %h, need no AR", issued, m_if.ar_addr);
        end else if (m_if.ar_addr !== exp_addr[issued] || m_if.ar_len !== 8'd0 || m_if.ar_burst !== 2'b01 ||
                     m_if.ar_id !== t_id || m_if.ar_size !== t_size || m_if.ar_prot !== 3'b010) begin
          miscompares++;
          $display("FAIL ar_beat%0d: got addr %h len %0d burst %b id %h size %0d, need addr %h len 0 burst 01 id %h size %0d",
                   issued, m_if.ar_addr, m_if.ar_len, m_if.ar_burst, m_if.ar_id, m_if.ar_size,
                   exp_addr[issued], t_id, t_size);
        end
        q_addr.push_back(m_if.ar_addr); q_id.push_back(m_if.ar_id);
        issued++;
      end
      if (s_if.r_valid === 1'b1 && s_if.r_ready) begin
        exp_data = {24'hD00D00, 8'(rcv), exp_addr[rcv][31:0]};
        exp_last = (rcv == int'(t_len));
        vectors++;
        if (s_if.r_data !== exp_data || s_if.r_resp !== resp_for(rcv) || s_if.r_id !== t_id ||
            s_if.r_last !== exp_last || s_if.r_user !== 1'(rcv)) begin
          miscompares++;
          $display("FAIL r_beat%0d: got data %h resp %b id %h last %b, need data %h resp %b id %h last %b",
                   rcv, s_if.r_data, s_if.r_resp, s_if.r_id, s_if.r_last, exp_data, resp_for(rcv), t_id, exp_last);
        end
        if (exp_last) begin
          vectors++;
          if (s_if.ar_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ar_ready_at_last: got %b need 0", s_if.ar_ready);
          end
        end
        void'(q_addr.pop_front()); void'(q_id.pop_front());
        rcv++;
        if (rcv == int'(t_len) + 1) done = 1;
      end
      if (issued - rcv > max_seen) max_seen = issued - rcv;
      if (cyc == r_delay - 1) issued_pre = issued;
      if (abort_at >= 0 && rcv == abort_at) done = 1;
      step();
    end
    m_if.r_valid = 1'b0;
    s_if.r_ready = 1'b1;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL burst_timeout: got %0d beats, need %0d", rcv, int'(t_len) + 1);
    end
    if (abort_at < 0) begin
      vectors++;
      if (issued != int'(t_len) + 1 || rcv != int'(t_len) + 1) begin
        miscompares++;
        $display("FAIL beat_count: got %0d ARs %0d Rs, need %0d each", issued, rcv, int'(t_len) + 1);
      end
      #4;
      vectors++;
      if (s_if.ar_ready !== 1'b1 || m_if.ar_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after_last: s_ar_ready %b m_ar_valid %b, need 1 0", s_if.ar_ready, m_if.ar_valid);
      end
      step();
    end
  endtask

  task automatic test_reset();
    s_if.ar_valid = 1'b1; s_if.ar_id = '0; s_if.ar_addr = '0; s_if.ar_len = '0;
    s_if.ar_size = '0; s_if.ar_burst = 2'b01; s_if.ar_prot = '0; s_if.ar_user = '0;
    s_if.r_ready = 1'b1; m_if.ar_ready = 1'b1;
    m_if.r_valid = 1'b1; m_if.r_id = '0; m_if.r_data = '0; m_if.r_resp = '0;
    m_if.r_last = 1'b0; m_if.r_user = '0;
    rst = 1'b1;
    step(); step();
    #4;
    vectors++;
    if (s_if.ar_ready !== 1'b0 || m_if.ar_valid !== 1'b0 || s_if.r_valid !== 1'b0 || m_if.r_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: ar_ready %b m_ar_valid %b s_r_valid %b m_r_ready %b, need 0 0 0 0",
               s_if.ar_ready, m_if.ar_valid, s_if.r_valid, m_if.r_ready);
    end
    step();
    rst = 1'b0; s_if.ar_valid = 1'b0; m_if.r_valid = 1'b0;
    #4;
    vectors++;
    if (s_if.ar_ready !== 1'b1 || m_if.ar_valid !== 1'b0 || s_if.r_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: ar_ready %b m_ar_valid %b s_r_valid %b, need 1 0 0",
               s_if.ar_ready, m_if.ar_valid, s_if.r_valid);
    end
    step();
  endtask

  task automatic test_incr();
    set_defaults();
    exp_addr[0] = 64'h8000_0004; exp_addr[1] = 64'h8000_0008;
    exp_addr[2] = 64'h8000_0010; exp_addr[3] = 64'h8000_0018;
    run_burst(4'h3, 64'h8000_0004, 8'd3, 3'd3, 2'b01);
  endtask

  task automatic test_wrap();
    set_defaults();
    exp_addr[0] = 64'h8000_0010; exp_addr[1] = 64'h8000_0018;
    exp_addr[2] = 64'h8000_0000; exp_addr[3] = 64'h8000_0008;
    run_burst(4'h5, 64'h8000_0010, 8'd3, 3'd3, 2'b10);
  endtask

  task automatic test_fixed();
    set_defaults();
    for (int i = 0; i < 3; i++) exp_addr[i] = 64'h1236;
    run_burst(4'h1, 64'h1236, 8'd2, 3'd2, 2'b00);
  endtask

  task automatic test_wrap_bad_len();
    set_defaults();
    exp_addr[0] = 64'h100C; exp_addr[1] = 64'h1010; exp_addr[2] = 64'h1014;
    run_burst(4'h2, 64'h100C, 8'd2, 3'd2, 2'b10);
  endtask

  task automatic test_max_out();
    set_defaults();
    r_delay = 12;
    for (int i = 0; i < 16; i++) exp_addr[i] = 64'h2000_0000 + 64'(i * 8);
    run_burst(4'h7, 64'h2000_0000, 8'd15, 3'd3, 2'b01);
    vectors++;
    if (issued_pre != MO || max_seen != MO) begin
      miscompares++;
      $display("FAIL max_out: issued before R %0d peak %0d, need %0d %0d", issued_pre, max_seen, MO, MO);
    end
  endtask

  task automatic test_backpressure();
    set_defaults();
    stall_start = 3; stall_len = 10;
    for (int i = 0; i < 8; i++) exp_addr[i] = 64'h4000 + 64'(i * 4);
    run_burst(4'h9, 64'h4000, 8'd7, 3'd2, 2'b01);
  endtask

  task automatic test_error_resp();
    set_defaults();
    err_mode = 1;
    for (int i = 0; i < 4; i++) exp_addr[i] = 64'h5000 + 64'(i * 8);
    run_burst(4'hA, 64'h5000, 8'd3, 3'd3, 2'b01);
  endtask

  task automatic test_single_beat();
    set_defaults();
    exp_addr[0] = 64'h3003;
    run_burst(4'h4, 64'h3003, 8'd0, 3'd0, 2'b01);
  endtask

  task automatic test_back_to_back();
    set_defaults();
    exp_addr[0] = 64'h6008; exp_addr[1] = 64'h6000;
    run_burst(4'hB, 64'h6008, 8'd1, 3'd3, 2'b10);
    exp_addr[0] = 64'h7001; exp_addr[1] = 64'h7002;
    run_burst(4'hC, 64'h7001, 8'd1, 3'd1, 2'b01);
  endtask

  task automatic test_reset_mid_burst();
    set_defaults();
    abort_at = 2;
    for (int i = 0; i < 8; i++) exp_addr[i] = 64'h1000 + 64'(i * 8);
    run_burst(4'h6, 64'h1000, 8'd7, 3'd3, 2'b01);
    rst = 1'b1; m_if.r_valid = 1'b1;
    #4;
    vectors++;
    if (s_if.ar_ready !== 1'b0 || m_if.ar_valid !== 1'b0 || s_if.r_valid !== 1'b0 || m_if.r_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: ar_ready %b m_ar_valid %b s_r_valid %b m_r_ready %b, need 0 0 0 0",
               s_if.ar_ready, m_if.ar_valid, s_if.r_valid, m_if.r_ready);
    end
    step();
    rst = 1'b0; m_if.r_valid = 1'b0;
    #4;
    vectors++;
    if (s_if.ar_ready !== 1'b1 || m_if.ar_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_release: ar_ready %b m_ar_valid %b, need 1 0", s_if.ar_ready, m_if.ar_valid);
    end
    step();
    set_defaults();
    exp_addr[0] = 64'h9000;
    run_burst(4'hD, 64'h9000, 8'd0, 3'd3, 2'b01);
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_wrap_bad_len();
    test_max_out();
    test_backpressure();
    test_error_resp();
    test_single_beat();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule
